// File: rtl/poisson_array_scheduler.sv
// Timestep scheduler sweeping a neuron state array through an update unit.
// Optional macro POISSON_OVERRUN_CNT_EN enables the dropped-tick counter.
module poisson_array_scheduler #(
    parameter int N_NEURONS  = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int NEUR_WIDTH = 13,
    parameter int DT_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sched_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [NEUR_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [NEUR_WIDTH-1:0] mem_wr_data,
    output logic                  poisson_en,
    output logic [NEUR_WIDTH-1:0] poisson_in,
    input  logic [NEUR_WIDTH-1:0] poisson_out,
    input  logic                  spike,
    input  logic                  host_wr_req,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [NEUR_WIDTH-1:0] host_wr_data,
    output logic                  host_wr_ack,
    output logic                  spike_valid,
    output logic [ADDR_WIDTH-1:0] spike_addr,
    output logic                  busy,
    output logic                  sweep_done,
    output logic [15:0]           overrun_cnt
);

    localparam int DT_W = $clog2(DT_CYCLES + 1);
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DT_W-1:0]         dt_cnt;
    logic                    tick;
    logic                    tick_pending;
    logic                    go;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    drain_cnt;
    logic                    s1_valid;
    logic [ADDR_WIDTH-1:0]   s1_addr;
    logic                    s2_valid;
    logic [ADDR_WIDTH-1:0]   s2_addr;
    logic                    done_q;

    assign tick = sched_en && (dt_cnt == DT_LAST);
    assign go   = (state == IDLE) && tick_pending;

    // timestep counter, parked at zero while scheduling is disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dt_cnt <= '0;
        else if (!sched_en || dt_cnt == DT_LAST)
            dt_cnt <= '0;
        else
            dt_cnt <= dt_cnt + DT_W'(1);
    end

    // one-deep tick latch; a tick while it is already set is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_pending <= 1'b0;
        else if (go)
            tick_pending <= 1'b0;
        else if (tick)
            tick_pending <= 1'b1;
    end

    // sweep controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // sweep controller next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (tick_pending) state_nxt = SWEEP;
            SWEEP:   if (rd_addr == A_LAST) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // read address walk, drain timer and sweep completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr   <= '0;
            drain_cnt <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_addr   <= (state == SWEEP && rd_addr != A_LAST)
                         ? rd_addr + ADDR_WIDTH'(1) : '0;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            done_q    <= (state == DRAIN) && drain_cnt;
        end
    end

    // address/valid delay line matching memory and update-unit latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
        end else begin
            s1_valid <= mem_rd_en;
            s1_addr  <= mem_rd_addr;
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
        end
    end

    // host writes only slip into quiet idle cycles; sweeps win
    always_comb begin
        host_wr_ack = !reset && host_wr_req && (state == IDLE) &&
                      !tick_pending && !done_q && !s2_valid;
    end

    // datapath and status outputs
    always_comb begin
        mem_rd_en   = (state == SWEEP);
        mem_rd_addr = mem_rd_en ? rd_addr : '0;
        poisson_en  = s1_valid;
        poisson_in  = s1_valid ? mem_rd_data : '0;
        mem_wr_en   = s2_valid || host_wr_ack;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        if (s2_valid) begin
            mem_wr_addr = s2_addr;
            mem_wr_data = poisson_out;
        end else if (host_wr_ack) begin
            mem_wr_addr = host_wr_addr;
            mem_wr_data = host_wr_data;
        end
        spike_valid = s2_valid && spike;
        spike_addr  = spike_valid ? s2_addr : '0;
        busy        = (state != IDLE);
        sweep_done  = done_q;
    end

`ifdef POISSON_OVERRUN_CNT_EN
    logic        overrun;
    logic [15:0] ovr_q;

    assign overrun = tick && tick_pending;

    // saturating count of lost ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovr_q <= '0;
        else if (overrun && ovr_q != 16'hFFFF)
            ovr_q <= ovr_q + 16'd1;
    end

    assign overrun_cnt = ovr_q;
`else
    assign overrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_poisson_array_scheduler.sv
// Scoreboard bench: a memory and update-unit model around the scheduler,
// plus a fast-tick instance for overrun behaviour.
module tb_poisson_array_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        sched_en;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [12:0] mem_rd_data;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr;
    logic [12:0] mem_wr_data;
    logic        poisson_en;
    logic [12:0] poisson_in;
    logic [12:0] poisson_out;
    logic        spike;
    logic        host_wr_req;
    logic [7:0]  host_wr_addr;
    logic [12:0] host_wr_data;
    logic        host_wr_ack;
    logic        spike_valid;
    logic [7:0]  spike_addr;
    logic        busy;
    logic        sweep_done;
    logic [15:0] overrun_cnt;

    logic        sched_en2;
    logic        rd_en2;
    logic [7:0]  rd_addr2;
    logic        wr_en2;
    logic [7:0]  wr_addr2;
    logic [12:0] wr_data2;
    logic        pen2;
    logic [12:0] pin2;
    logic        ack2;
    logic        sv2;
    logic [7:0]  sa2;
    logic        busy2;
    logic        done2;
    logic [15:0] ovr2;

    int tests = 0;
    int fails = 0;
    int spikes = 0;
    int cyc;
    logic        sb_on = 1'b0;
    logic [12:0] mem [0:3];
    logic [7:0]  s1a;
    logic [7:0]  q_addr [$];
    logic [12:0] q_data [$];
    int          q_cyc  [$];

    always #5 clk = ~clk;

    poisson_array_scheduler #(
        .N_NEURONS(4), .ADDR_WIDTH(8), .NEUR_WIDTH(13), .DT_CYCLES(16)
    ) u_dut (
        .clk(clk), .reset(rst), .sched_en(sched_en),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .poisson_en(poisson_en), .poisson_in(poisson_in),
        .poisson_out(poisson_out), .spike(spike),
        .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data), .host_wr_ack(host_wr_ack),
        .spike_valid(spike_valid), .spike_addr(spike_addr),
        .busy(busy), .sweep_done(sweep_done), .overrun_cnt(overrun_cnt)
    );

    poisson_array_scheduler #(
        .N_NEURONS(4), .ADDR_WIDTH(8), .NEUR_WIDTH(13), .DT_CYCLES(3)
    ) u_ovr (
        .clk(clk), .reset(rst), .sched_en(sched_en2),
        .mem_rd_en(rd_en2), .mem_rd_addr(rd_addr2),
        .mem_rd_data(13'd0),
        .mem_wr_en(wr_en2), .mem_wr_addr(wr_addr2),
        .mem_wr_data(wr_data2),
        .poisson_en(pen2), .poisson_in(pin2),
        .poisson_out(13'd0), .spike(1'b0),
        .host_wr_req(1'b0), .host_wr_addr(8'd0),
        .host_wr_data(13'd0), .host_wr_ack(ack2),
        .spike_valid(sv2), .spike_addr(sa2),
        .busy(busy2), .sweep_done(done2), .overrun_cnt(ovr2)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // state memory (1-cycle read) and update unit (data+1, spike at 2)
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= 13'(100 * (i + 1));
            mem_rd_data <= '0;
            poisson_out <= '0;
            spike       <= 1'b0;
            s1a         <= '0;
        end else begin
            if (mem_wr_en) mem[mem_wr_addr[1:0]] <= mem_wr_data;
            mem_rd_data <= mem[mem_rd_addr[1:0]];
            s1a         <= mem_rd_addr;
            poisson_out <= poisson_in + 13'd1;
            spike       <= poisson_en && (s1a == 8'd2);
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        sched_en = 1'b1;
        sched_en2 = 1'b1;
        host_wr_req = 1'b1;
        host_wr_addr = 8'd3;
        host_wr_data = 13'd5;
        repeat (3) @(negedge clk);
        tests++;
        if ({mem_rd_en, mem_wr_en, poisson_en, host_wr_ack} !== 4'b0) begin
            fails++;
            $display("FAIL rst_ctl: got %b want 0000",
                     {mem_rd_en, mem_wr_en, poisson_en, host_wr_ack});
        end
        tests++;
        if ({spike_valid, busy, sweep_done} !== 3'b0) begin
            fails++;
            $display("FAIL rst_stat: got %b want 000",
                     {spike_valid, busy, sweep_done});
        end
        tests++;
        if ({mem_rd_addr, mem_wr_addr, mem_wr_data, poisson_in} !== '0) begin
            fails++;
            $display("FAIL rst_bus: rd %h wr %h/%h pin %h want 0",
                     mem_rd_addr, mem_wr_addr, mem_wr_data, poisson_in);
        end
        tests++;
        if (overrun_cnt !== 16'd0 || ovr2 !== 16'd0) begin
            fails++;
            $display("FAIL rst_ovr: got %0d/%0d want 0", overrun_cnt, ovr2);
        end
        host_wr_req = 1'b0;
        sched_en2 = 1'b0;
    endtask

    task automatic test_first_sweep();
        int first;
        int t;
        sched_en = 1'b1;
        rst = 1'b0;
        first = -1;
        for (t = 0; t < 40 && first < 0; t++) begin
            @(negedge clk);
            if (mem_rd_en) first = cyc;
        end
        tests++;
        if (first != 17) begin
            fails++;
            $display("FAIL first_read: cycle %0d want 17", first);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (!mem_rd_en || mem_rd_addr !== 8'(k) || !busy) begin
                fails++;
                $display("FAIL rd_seq: en %b addr %0d busy %b want 1 %0d 1",
                         mem_rd_en, mem_rd_addr, busy, k);
            end
            @(negedge clk);
        end
        for (t = 0; t < 10 && !sweep_done; t++) @(negedge clk);
        tests++;
        if (!sweep_done || cyc != first + 6) begin
            fails++;
            $display("FAIL done_time: done %b cycle %0d want 1 %0d",
                     sweep_done, cyc, first + 6);
        end
        @(negedge clk);
        tests++;
        if (q_addr.size() != 0 || spikes != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL sweep1_end: left %0d spikes %0d busy %b want 0 1 0",
                     q_addr.size(), spikes, busy);
        end
        tests++;
        if (mem[0] !== 13'd101 || mem[3] !== 13'd401) begin
            fails++;
            $display("FAIL mem_upd: %0d %0d want 101 401", mem[0], mem[3]);
        end
    endtask

    task automatic test_host_priority();
        int done_at;
        int ack_at;
        int t;
        done_at = -1;
        ack_at = -1;
        for (t = 0; t < 40 && !busy; t++) @(negedge clk);
        host_wr_req = 1'b1;
        host_wr_addr = 8'd1;
        host_wr_data = 13'h0ABC;
        for (t = 0; t < 40 && ack_at < 0; t++) begin
            if (sweep_done) done_at = cyc;
            if (host_wr_ack) begin
                ack_at = cyc;
                tests++;
                if (busy || !mem_wr_en || mem_wr_addr !== 8'd1 ||
                    mem_wr_data !== 13'h0ABC) begin
                    fails++;
                    $display("FAIL host_wr: busy %b en %b a %0d d %h",
                             busy, mem_wr_en, mem_wr_addr, mem_wr_data);
                end
            end else begin
                @(negedge clk);
            end
        end
        tests++;
        if (ack_at < 0 || done_at < 0 || ack_at <= done_at) begin
            fails++;
            $display("FAIL host_order: ack %0d done %0d want ack after done",
                     ack_at, done_at);
        end
        @(posedge clk);
        #1 host_wr_req = 1'b0;
        @(negedge clk);
        tests++;
        if (mem[1] !== 13'h0ABC || host_wr_ack !== 1'b0 || spikes != 2) begin
            fails++;
            $display("FAIL host_end: mem1 %h ack %b spikes %0d want abc 0 2",
                     mem[1], host_wr_ack, spikes);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int t;
        int wr_seen;
        int first;
        wr_seen = 0;
        first = -1;
        for (t = 0; t < 40 && !(mem_rd_en && mem_rd_addr == 8'd1); t++)
            @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({mem_rd_en, mem_wr_en, poisson_en, busy, spike_valid} !== 5'b0) begin
            fails++;
            $display("FAIL rst_mid: got %b want 00000",
                     {mem_rd_en, mem_wr_en, poisson_en, busy, spike_valid});
        end
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        repeat (3) begin
            @(negedge clk);
            if (mem_wr_en) wr_seen++;
        end
        rst = 1'b0;
        for (t = 0; t < 40 && first < 0; t++) begin
            @(negedge clk);
            if (mem_rd_en) first = cyc;
            else if (mem_wr_en) wr_seen++;
        end
        tests++;
        if (wr_seen != 0) begin
            fails++;
            $display("FAIL rst_nowr: %0d writes want 0", wr_seen);
        end
        tests++;
        if (first != 17 || mem_rd_addr !== 8'd0) begin
            fails++;
            $display("FAIL rst_restart: cycle %0d addr %0d want 17 0",
                     first, mem_rd_addr);
        end
        for (t = 0; t < 10 && !sweep_done; t++) @(negedge clk);
        tests++;
        if (!sweep_done || q_addr.size() != 0) begin
            fails++;
            $display("FAIL rst_sweep: done %b left %0d want 1 0",
                     sweep_done, q_addr.size());
        end
    endtask

    task automatic test_overrun();
        int sweeps;
        int exp_ovr;
        logic after_done;
        logic b2b_checked;
        sweeps = 0;
        after_done = 1'b0;
        b2b_checked = 1'b0;
        sched_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sched_en2 = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (after_done && !b2b_checked) begin
                b2b_checked = 1'b1;
                tests++;
                if (!rd_en2 || rd_addr2 !== 8'd0) begin
                    fails++;
                    $display("FAIL b2b: en %b addr %0d want 1 0",
                             rd_en2, rd_addr2);
                end
            end
            after_done = done2;
            if (done2) sweeps++;
            if (i == 29) sched_en2 = 1'b0;
        end
`ifdef POISSON_OVERRUN_CNT_EN
        exp_ovr = 5;
`else
        exp_ovr = 0;
`endif
        tests++;
        if (sweeps != 5 || busy2 !== 1'b0) begin
            fails++;
            $display("FAIL ovr_sweeps: %0d busy %b want 5 0", sweeps, busy2);
        end
        tests++;
        if (ovr2 !== 16'(exp_ovr)) begin
            fails++;
            $display("FAIL ovr_cnt: %0d want %0d", ovr2, exp_ovr);
        end
    endtask

    initial begin
        sched_en2 = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (!rst && sb_on) begin
                    if (mem_rd_en) begin
                        q_addr.push_back(mem_rd_addr);
                        q_data.push_back(mem[mem_rd_addr[1:0]] + 13'd1);
                        q_cyc.push_back(cyc + 2);
                    end
                    if (mem_wr_en && !host_wr_ack) begin
                        tests++;
                        if (q_addr.size() == 0) begin
                            fails++;
                            $display("FAIL wr_unexp: addr %0d none expected",
                                     mem_wr_addr);
                        end else if (mem_wr_addr !== q_addr[0] ||
                                     mem_wr_data !== q_data[0] ||
                                     cyc != q_cyc[0]) begin
                            fails++;
                            $display("FAIL wr_sb: a %0d d %0d c %0d want %0d %0d %0d",
                                     mem_wr_addr, mem_wr_data, cyc,
                                     q_addr[0], q_data[0], q_cyc[0]);
                        end
                        if (q_addr.size() != 0) begin
                            void'(q_addr.pop_front());
                            void'(q_data.pop_front());
                            void'(q_cyc.pop_front());
                        end
                    end
                    if (spike_valid) begin
                        spikes++;
                        tests++;
                        if (spike_addr !== 8'd2 || mem_wr_addr !== 8'd2) begin
                            fails++;
                            $display("FAIL spike: addr %0d wr %0d want 2 2",
                                     spike_addr, mem_wr_addr);
                        end
                    end
                end
            end
        join_none
        test_reset();
        sb_on = 1'b1;
        test_first_sweep();
        test_host_priority();
        test_reset_mid_sweep();
        sb_on = 1'b0;
        test_overrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
